elev_timer_bank: RTL and testbench
==================================

Name: elev_timer_bank

Overview:
Bank of NUM_CH independent kick-started countdown timers for the elevator controller. It replaces the single fixed 1 s door/dwell timer and serves door-open dwell, door-close timeout, floor-travel watchdog and idle-return from one block. Each channel has the following:
- a per-kick programmable terminal count, with a default fallback
- one-shot or periodic mode
- cancel
- a one-cycle expiry pulse plus a sticky expired flag

It sits between the main controller FSM and the clock domain, driven by kick/cancel strobes.

Parameters:
NUM_CH, 4, number of independent timer channels
CNT_W, 28, counter and terminal-count width per channel
DEFAULT_COUNT, 50000000, terminal count used when the loaded count_val slice is 0 (1 s at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
kick  input  NUM_CH  per-channel start/restart request; rising-edge sensitive
cancel  input  NUM_CH  per-channel stop; level sampled each cycle
periodic  input  NUM_CH  per-channel mode, sampled with the kick edge: 1 = auto-reload, 0 = one-shot
count_val  input  NUM_CH*CNT_W  per-channel terminal count; channel i uses bits [i*CNT_W +: CNT_W]; sampled with the kick edge
busy  output  NUM_CH  channel in RUN
expire_pulse  output  NUM_CH  one-cycle strobe at each expiry
expired  output  NUM_CH  sticky expiry flag; cleared by kick edge, cancel or reset

Behaviour:
- Reset: all channels go to IDLE; counter=0, limit=DEFAULT_COUNT, mode=0; busy, expire_pulse and expired all 0; kick_q (edge-detect register) set to 1, so a kick held high through reset is not an edge until it drops.
- Kick edge: kick[i]=1 and kick_q[i]=0 in the same cycle.
- Per-channel states: IDLE, RUN, DONE.
- Priority per channel, per cycle: reset > cancel > kick edge > counting.
- Cancel, in any state: go to IDLE, counter=0, expired=0, no expire_pulse.
  - Cancel in the same cycle as an expiry suppresses the pulse.
- Kick edge, in any state including RUN (restart):
  - limit = count_val slice, or DEFAULT_COUNT if the slice is 0
  - mode = periodic[i]
  - counter=0, expired=0, state RUN
- Timing: with the kick edge sampled at edge E, expire_pulse is high for the cycle following edge E+limit, so the latency is limit cycles.
- RUN: counter increments by 1 per cycle. When counter == limit-1:
  - expire_pulse=1 next cycle and expired=1
  - one-shot: go to DONE, counter=0
  - periodic: counter=0, stay in RUN, pulse repeats every limit cycles
- DONE: hold with expired=1 and busy=0 until a kick edge or cancel.
- Kick held high: no effect after its edge. Only a new 0->1 transition restarts the channel.
- count_val=1 gives a pulse 1 cycle after the kick. Periodic with limit 1 pulses every cycle.
- Counter compare is unsigned. The counter never exceeds limit-1, so wrap-around is impossible.
- busy = (state == RUN). Outputs are registered; there is no combinational path from inputs to outputs.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
Macro ELEV_TIMER_PAUSE_EN.
- Defined: adds input port pause [NUM_CH].
  - While pause[i]=1 in RUN, counter[i] holds and no expiry occurs.
  - Kick and cancel still act during pause; a kick edge during pause reloads but does not count until pause drops.
  - Used for door-obstruction hold.
- Undefined: no pause port; counters always advance in RUN.

Decomposition:
- Package elev_timer_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE (2-bit)
  - DEFAULT_COUNT default value
  - simulation value SIM_COUNT=8
- Sub-module elev_timer_ch implements one channel:
  - edge detect, FSM, counter, outputs
  - parameters CNT_W and DEFAULT_COUNT
- The top level is a generate loop over NUM_CH plus count_val slicing.

Test Plan (CNT_W=8, DEFAULT_COUNT=8, NUM_CH=4):
1. Reset, then kick[0] edge with count_val[0]=0, one-shot -> busy[0]=1 for 8 cycles; expire_pulse[0] high exactly 8 cycles after the kick edge; expired[0]=1 held; busy[0]=0.
2. kick[1] edge with count_val[1]=3, periodic=1 -> expire_pulse[1] at +3, +6, +9 cycles; busy[1] stays 1; cancel at +7 -> no pulse at +9, expired[1]=0, busy[1]=0.
3. kick[2] edge with count_val[2]=5; re-kick (new edge) at +3 -> pulse at +8 from the first kick, not at +5; kick held high for 20 cycles -> single expiry only.
4. kick[3] and cancel[3] asserted in the same cycle -> channel stays IDLE, no pulse. Cancel coincident with the terminal cycle -> expire_pulse suppressed.
5. Reset asserted mid-RUN on all channels -> all outputs 0 the next cycle; kick held high across reset release gives no start until the kick drops and rises.
6. With ELEV_TIMER_PAUSE_EN: count_val=4, pause for cycles +2..+5 -> expiry at +8 instead of +4; without the macro the pause port is absent and the build passes.

Source files
------------

// File: rtl/elev_timer_pkg.sv
// Shared definitions for the elevator timer bank: channel state encoding and
// terminal-count defaults.
package elev_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 1 s at 50 MHz
  localparam int unsigned DEFAULT_COUNT = 50000000;
  localparam int unsigned SIM_COUNT     = 8;

endpackage

// File: rtl/elev_timer_bank_if.sv
// Strobe/status bundle between the controller FSM and elev_timer_bank.
// ELEV_TIMER_PAUSE_EN adds the per-channel pause input.
interface elev_timer_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 28
);
  logic [NUM_CH-1:0]       kick;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*CNT_W-1:0] count_val;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       expire_pulse;
  logic [NUM_CH-1:0]       expired;
`ifdef ELEV_TIMER_PAUSE_EN
  logic [NUM_CH-1:0]       pause;
`endif

  modport master (
    output kick, cancel, periodic, count_val,
`ifdef ELEV_TIMER_PAUSE_EN
    output pause,
`endif
    input  busy, expire_pulse, expired
  );

  modport slave (
    input  kick, cancel, periodic, count_val,
`ifdef ELEV_TIMER_PAUSE_EN
    input  pause,
`endif
    output busy, expire_pulse, expired
  );

endinterface

// File: rtl/elev_timer_ch.sv
// One kick-started countdown channel: kick edge detect, IDLE/RUN/DONE FSM,
// up-counter against a latched limit. ELEV_TIMER_PAUSE_EN adds a pause input.
module elev_timer_ch #(
  parameter int unsigned CNT_W         = 28,
  parameter int unsigned DEFAULT_COUNT = elev_timer_pkg::DEFAULT_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kick,
  input  logic             cancel,
  input  logic             periodic,
  input  logic [CNT_W-1:0] count_val,
`ifdef ELEV_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             expire_pulse,
  output logic             expired
);
  import elev_timer_pkg::*;

  localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DEFAULT_COUNT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             kick_q, kick_d;
  logic             pulse_q, pulse_d;
  logic             expired_q, expired_d;
  logic             kick_edge;
  logic             advance;

`ifdef ELEV_TIMER_PAUSE_EN
  assign advance = ~pause;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;
    kick_d    = kick;
    kick_edge = kick & ~kick_q;

    // Cancel outranks a kick edge and also swallows a coincident expiry.
    if (cancel) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      expired_d = 1'b0;
    end else if (kick_edge) begin
      limit_d   = (count_val == '0) ? DEF_LIMIT : count_val;
      mode_d    = periodic;
      cnt_d     = '0;
      expired_d = 1'b0;
      state_d   = ST_RUN;
    end else if (state_q == ST_RUN && advance) begin
      if (cnt_q == limit_q - ONE) begin
        pulse_d   = 1'b1;
        expired_d = 1'b1;
        cnt_d     = '0;
        if (!mode_q) state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // kick_q resets high so a kick held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      limit_q   <= DEF_LIMIT;
      mode_q    <= 1'b0;
      kick_q    <= 1'b1;
      pulse_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      kick_q    <= kick_d;
      pulse_q   <= pulse_d;
      expired_q <= expired_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign expire_pulse = pulse_q;
  assign expired      = expired_q;

endmodule

// File: rtl/elev_timer_bank.sv
// Bank of NUM_CH independent countdown timers for the elevator controller.
// Optional ELEV_TIMER_PAUSE_EN enables per-channel pause via the interface.
module elev_timer_bank #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 28,
  parameter int unsigned DEFAULT_COUNT = elev_timer_pkg::DEFAULT_COUNT
) (
  input logic               clk,
  input logic               reset,
  elev_timer_bank_if.slave  bus
);

  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] pulse_w;
  logic [NUM_CH-1:0] expired_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    elev_timer_ch #(
      .CNT_W         (CNT_W),
      .DEFAULT_COUNT (DEFAULT_COUNT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .kick         (bus.kick[i]),
      .cancel       (bus.cancel[i]),
      .periodic     (bus.periodic[i]),
      .count_val    (bus.count_val[i*CNT_W +: CNT_W]),
`ifdef ELEV_TIMER_PAUSE_EN
      .pause        (bus.pause[i]),
`endif
      .busy         (busy_w[i]),
      .expire_pulse (pulse_w[i]),
      .expired      (expired_w[i])
    );
  end

  assign bus.busy         = busy_w;
  assign bus.expire_pulse = pulse_w;
  assign bus.expired      = expired_w;

endmodule

// File: tb/tb_elev_timer_bank.sv
// Self-checking bench for elev_timer_bank: directed scenarios plus random
// traffic, each cycle compared against an elapsed-tick reference model.
module tb_elev_timer_bank;
  import elev_timer_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned DEF = SIM_COUNT;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  kick_r, cancel_r, per_r, pause_r, pause_eff;
  logic [CW-1:0]   cv_r [NCH];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;

  // Reference model: a channel is "active" after a kick edge and fires whenever
  // the number of non-paused cycles since that kick is a multiple of its limit.
  logic [NCH-1:0]  m_prev, m_act, m_per, m_exp, m_pulse;
  int unsigned     m_lim   [NCH];
  int unsigned     m_ticks [NCH];

  elev_timer_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  elev_timer_bank #(
    .NUM_CH        (NCH),
    .CNT_W         (CW),
    .DEFAULT_COUNT (DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.kick     = kick_r;
  assign bus.cancel   = cancel_r;
  assign bus.periodic = per_r;
  for (genvar g = 0; g < NCH; g++) begin : g_cv
    assign bus.count_val[g*CW +: CW] = cv_r[g];
  end
`ifdef ELEV_TIMER_PAUSE_EN
  assign bus.pause = pause_r;
  assign pause_eff = pause_r;
`else
  assign pause_eff = '0;
`endif

  task automatic model_edge();
    if (reset) begin
      m_prev = '1; m_act = '0; m_per = '0; m_exp = '0; m_pulse = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        m_lim[c] = DEF; m_ticks[c] = 0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        logic e;
        e = kick_r[c] && !m_prev[c];
        m_prev[c]  = kick_r[c];
        m_pulse[c] = 1'b0;
        if (cancel_r[c]) begin
          m_act[c] = 1'b0; m_exp[c] = 1'b0;
        end else if (e) begin
          m_lim[c]   = (cv_r[c] == 0) ? DEF : int'(cv_r[c]);
          m_per[c]   = per_r[c];
          m_ticks[c] = 0;
          m_act[c]   = 1'b1;
          m_exp[c]   = 1'b0;
        end else if (m_act[c] && !pause_eff[c]) begin
          m_ticks[c]++;
          if (m_ticks[c] % m_lim[c] == 0) begin
            m_pulse[c] = 1'b1;
            m_exp[c]   = 1'b1;
            if (!m_per[c]) m_act[c] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_all();
    kick_r = '0; cancel_r = '1; per_r = '0; pause_r = '0;
    step();
    cancel_r = '0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; kick_r = '0; cancel_r = '0; per_r = '0; pause_r = '0;
    for (int unsigned c = 0; c < NCH; c++) cv_r[c] = '0;
    repeat (3) step();
    n_chk++;
    if ({bus.busy, bus.expire_pulse, bus.expired} !== 12'h000)
      $display("FAIL reset_outputs got b=%b p=%b e=%b want all 0",
               bus.busy, bus.expire_pulse, bus.expired);
    else n_pass++;
    reset = 1'b0;
    step();
    n_chk++;
    if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
      $display("FAIL reset_release got b=%b p=%b e=%b want b=%b p=%b e=%b",
               bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
    else n_pass++;
  endtask

  task automatic test_oneshot_default();
    int pulse_at = -1;
    int unsigned npulse = 0, nbusy = 0;
    cv_r[0] = '0; per_r[0] = 1'b0; kick_r[0] = 1'b1;
    for (int unsigned j = 0; j < 12; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL oneshot_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      if (bus.expire_pulse[0]) begin
        if (pulse_at < 0) pulse_at = int'(j);
        npulse++;
      end
      if (bus.busy[0]) nbusy++;
      if (j == 0) kick_r[0] = 1'b0;
    end
    n_chk++;
    if (pulse_at !== 8) $display("FAIL oneshot_latency got %0d want 8", pulse_at);
    else n_pass++;
    n_chk++;
    if (nbusy !== 8 || npulse !== 1)
      $display("FAIL oneshot_busy_cycles got busy=%0d pulses=%0d want 8 and 1", nbusy, npulse);
    else n_pass++;
    n_chk++;
    if (bus.expired[0] !== 1'b1 || bus.busy[0] !== 1'b0)
      $display("FAIL oneshot_done got exp=%b busy=%b want 1 0", bus.expired[0], bus.busy[0]);
    else n_pass++;
  endtask

  task automatic test_periodic_cancel();
    int unsigned pq[$];
    int unsigned nbusy = 0;
    cv_r[1] = 8'd3; per_r[1] = 1'b1; kick_r[1] = 1'b1;
    for (int unsigned j = 0; j < 13; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL periodic_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      if (bus.expire_pulse[1]) pq.push_back(j);
      if (bus.busy[1]) nbusy++;
      if (j == 0) kick_r[1] = 1'b0;
      if (j == 6) cancel_r[1] = 1'b1;
      if (j == 7) cancel_r[1] = 1'b0;
    end
    n_chk++;
    if (pq.size() != 2 || pq[0] != 3 || pq[1] != 6)
      $display("FAIL periodic_pulses got n=%0d first=%0d second=%0d want 2 at 3 and 6",
               pq.size(), (pq.size() > 0) ? pq[0] : 0, (pq.size() > 1) ? pq[1] : 0);
    else n_pass++;
    n_chk++;
    if (nbusy !== 7 || bus.busy[1] !== 1'b0 || bus.expired[1] !== 1'b0)
      $display("FAIL periodic_cancel got busy_cycles=%0d busy=%b exp=%b want 7 0 0",
               nbusy, bus.busy[1], bus.expired[1]);
    else n_pass++;
    per_r[1] = 1'b0;
  endtask

  task automatic test_rekick();
    int pulse_at = -1;
    int unsigned npulse = 0;
    cv_r[2] = 8'd5; per_r[2] = 1'b0; kick_r[2] = 1'b1;
    for (int unsigned j = 0; j < 26; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL rekick_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      if (bus.expire_pulse[2]) begin
        if (pulse_at < 0) pulse_at = int'(j);
        npulse++;
      end
      if (j == 0) kick_r[2] = 1'b0;
      if (j == 2) kick_r[2] = 1'b1;
    end
    n_chk++;
    if (pulse_at !== 8 || npulse !== 1)
      $display("FAIL rekick_pulse got at=%0d n=%0d want at=8 n=1", pulse_at, npulse);
    else n_pass++;
    kick_r[2] = 1'b0;
  endtask

  task automatic test_kick_cancel_same();
    int unsigned bad = 0;
    cv_r[3] = 8'd4; per_r[3] = 1'b0; kick_r[3] = 1'b1; cancel_r[3] = 1'b1;
    for (int unsigned j = 0; j < 10; j++) begin
      step();
      if (bus.busy[3] || bus.expire_pulse[3] || bus.expired[3]) bad++;
      if (j == 0) begin kick_r[3] = 1'b0; cancel_r[3] = 1'b0; end
    end
    n_chk++;
    if (bad !== 0) $display("FAIL kick_cancel_same got active_cycles=%0d want 0", bad);
    else n_pass++;
    bad = 0;
    kick_r[3] = 1'b1;
    for (int unsigned j = 0; j < 9; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL cancel_terminal_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      if (bus.expire_pulse[3] || bus.expired[3]) bad++;
      if (j == 0) kick_r[3] = 1'b0;
      if (j == 3) cancel_r[3] = 1'b1;
      if (j == 4) cancel_r[3] = 1'b0;
    end
    n_chk++;
    if (bad !== 0 || bus.busy[3] !== 1'b0)
      $display("FAIL cancel_terminal got expiry_cycles=%0d busy=%b want 0 0", bad, bus.busy[3]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int unsigned bad = 0;
    for (int unsigned c = 0; c < NCH; c++) cv_r[c] = 8'd6;
    per_r = 4'b1010; kick_r = '1;
    repeat (4) step();
    reset = 1'b1;
    step();
    n_chk++;
    if ({bus.busy, bus.expire_pulse, bus.expired} !== 12'h000)
      $display("FAIL reset_mid_run got b=%b p=%b e=%b want all 0",
               bus.busy, bus.expire_pulse, bus.expired);
    else n_pass++;
    reset = 1'b0;
    for (int unsigned j = 0; j < 10; j++) begin
      step();
      if (bus.busy !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL held_kick_after_reset got busy_cycles=%0d want 0", bad);
    else n_pass++;
    kick_r = '0;
    step();
    kick_r = '1;
    step();
    n_chk++;
    if (bus.busy !== 4'hF) $display("FAIL restart_after_drop got busy=%b want 1111", bus.busy);
    else n_pass++;
    for (int unsigned j = 0; j < 14; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL restart_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
    end
    kick_r = '0; per_r = '0;
  endtask

`ifdef ELEV_TIMER_PAUSE_EN
  task automatic test_pause();
    int pulse_at = -1;
    cv_r[0] = 8'd4; per_r[0] = 1'b0; kick_r[0] = 1'b1;
    for (int unsigned j = 0; j < 12; j++) begin
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL pause_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      if (bus.expire_pulse[0] && pulse_at < 0) pulse_at = int'(j);
      if (j == 0) kick_r[0] = 1'b0;
      if (j == 1) pause_r[0] = 1'b1;
      if (j == 5) pause_r[0] = 1'b0;
    end
    n_chk++;
    if (pulse_at !== 8) $display("FAIL pause_latency got %0d want 8", pulse_at);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int unsigned npulse = 0;
    for (int unsigned j = 0; j < 600; j++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) kick_r[c] = ~kick_r[c];
        cancel_r[c] = ($urandom_range(0, 24) == 0);
        per_r[c]    = $urandom_range(0, 1) == 1;
        cv_r[c]     = 8'($urandom_range(0, 5));
        pause_r[c]  = ($urandom_range(0, 4) == 0);
      end
      step();
      n_chk++;
      if ({bus.busy, bus.expire_pulse, bus.expired} !== {m_act, m_pulse, m_exp})
        $display("FAIL random_model cyc=%0d got b=%b p=%b e=%b want b=%b p=%b e=%b",
                 j, bus.busy, bus.expire_pulse, bus.expired, m_act, m_pulse, m_exp);
      else n_pass++;
      npulse += $countones(bus.expire_pulse);
    end
    n_chk++;
    if (npulse == 0) $display("FAIL random_activity got 0 pulses want some");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_oneshot_default();
    idle_all();
    test_periodic_cancel();
    idle_all();
    test_rekick();
    idle_all();
    test_kick_cancel_same();
    idle_all();
    test_reset_mid_run();
    idle_all();
`ifdef ELEV_TIMER_PAUSE_EN
    test_pause();
    idle_all();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
